// File: rtl/arbiter_rr_4x8_if.sv
// rtl/arbiter_rr_4x8_if.sv - source/destination FIFO bundle seen by the round-robin router
interface arbiter_rr_4x8_if #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_Q     = 4
);
  // Source VC FIFO side
  logic [NUM_Q-1:0]     fifo_empty;
  logic [NUM_Q-1:0]     fifo_error;
  logic [DATA_SIZE-1:0] data_in0;
  logic [DATA_SIZE-1:0] data_in1;
  logic [DATA_SIZE-1:0] data_in2;
  logic [DATA_SIZE-1:0] data_in3;
  logic [NUM_Q-1:0]     pop;

  // Destination FIFO side
  logic [NUM_Q-1:0]     dest_pause;
  logic [NUM_Q-1:0]     push;
  logic [DATA_SIZE-1:0] data_out;

  // Status
  logic                 idle;
  logic                 err;
  logic [4:0]           word_count;

  // Arbiter side: consumes FIFO flags and data, drives strobes and status
  modport master (
    input  fifo_empty, fifo_error, data_in0, data_in1, data_in2, data_in3, dest_pause,
    output pop, push, data_out, idle, err, word_count
  );

  // Environment side: the FIFO banks
  modport slave (
    output fifo_empty, fifo_error, data_in0, data_in1, data_in2, data_in3, dest_pause,
    input  pop, push, data_out, idle, err, word_count
  );
endinterface

// File: rtl/arbiter_rr_4x8.sv
// rtl/arbiter_rr_4x8.sv - 4-input round-robin arbiter routing VC FIFO words to 4 destination FIFOs
module arbiter_rr_4x8 #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_Q     = 4
) (
  input  logic              clk,
  input  logic              reset,
  arbiter_rr_4x8_if.master  bus
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PAUSE  = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [1:0]           ptr_q;
  logic [1:0]           ptr_d;

  // pop_q: read strobe this cycle; sel_q: source whose data_out_pop is valid this cycle
  logic [NUM_Q-1:0]     pop_q;
  logic [NUM_Q-1:0]     grant_d;
  logic [NUM_Q-1:0]     sel_q;
  logic [NUM_Q-1:0]     push_q;
  logic [NUM_Q-1:0]     push_d;
  logic [DATA_SIZE-1:0] data_q;
  logic [DATA_SIZE-1:0] word_mux;
  logic                 err_q;
  logic [4:0]           cnt_q;

  logic [NUM_Q-1:0]     eligible;
  logic [1:0]           win;
  logic [1:0]           idx;
  logic                 win_found;

  // A queue popped last cycle still shows a stale non-empty flag, so it sits out one cycle
  assign eligible = ~bus.fifo_empty & ~pop_q;

  // Rotating-priority search from the pointer; the loop runs backwards so the
  // closest eligible queue to the pointer is the last, winning assignment
  always_comb begin
    win       = ptr_q;
    idx       = ptr_q;
    win_found = 1'b0;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (eligible[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  // Next state and grant; pause outranks everything, INIT always falls to IDLE
  always_comb begin
    state_d = state_q;
    grant_d = '0;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        if (|bus.dest_pause) begin
          state_d = ST_PAUSE;
        end else if (win_found) begin
          state_d      = ST_ACTIVE;
          grant_d[win] = 1'b1;
          ptr_d        = win + 2'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and round-robin pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Select the source word that is valid this cycle (one cycle after its pop)
  always_comb begin
    word_mux = '0;
    case (sel_q)
      4'b0001: word_mux = bus.data_in0;
      4'b0010: word_mux = bus.data_in1;
      4'b0100: word_mux = bus.data_in2;
      4'b1000: word_mux = bus.data_in3;
      default: word_mux = '0;
    endcase
  end

  // Destination decode from the two MSBs of the word being forwarded
  always_comb begin
    push_d = '0;
    push_d[word_mux[DATA_SIZE-1 -: 2]] = |sel_q;
  end

  // Pop/route pipeline; it keeps draining regardless of pause so in-flight words land
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_q  <= '0;
      sel_q  <= '0;
      push_q <= '0;
      data_q <= '0;
    end else begin
      pop_q  <= grant_d;
      sel_q  <= pop_q;
      push_q <= push_d;
      if (|sel_q) begin
        data_q <= word_mux;
      end
    end
  end

  // Sticky error flag and modulo-32 count of pushed words
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
      cnt_q <= 5'd0;
    end else begin
      err_q <= err_q | (|bus.fifo_error);
      cnt_q <= cnt_q + {4'd0, |push_q};
    end
  end

  assign bus.pop        = pop_q;
  assign bus.push       = push_q;
  assign bus.data_out   = data_q;
  assign bus.idle       = (state_q == ST_IDLE);
  assign bus.err        = err_q;
  assign bus.word_count = cnt_q;

  // Strobes must never select two queues at once
  a_pop_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(pop_q));
  a_push_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(push_q));

endmodule

// File: tb/tb_arbiter_rr_4x8.sv
// tb/tb_arbiter_rr_4x8.sv - self-checking bench for arbiter_rr_4x8 with FIFO and behaviour models
module tb_arbiter_rr_4x8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  arbiter_rr_4x8_if #(.DATA_SIZE(8), .NUM_Q(4)) bus ();

  arbiter_rr_4x8 #(.DATA_SIZE(8), .NUM_Q(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Source FIFO contents; a pop seen in cycle c updates data/empty during c+1
  logic [7:0] srcq [4][$];
  logic [3:0] pend0, pend1;

  // Behavioural model
  typedef struct {
    int         due;
    logic [3:0] dst;
    logic [7:0] word;
  } ev_t;
  ev_t        evq[$];
  int         m_ptr, m_last;
  bit         m_init;
  logic [3:0] exp_pop, exp_push;
  logic [7:0] exp_data;
  logic       exp_idle, exp_err;
  logic [4:0] exp_cnt;

  // Observation logs
  logic [3:0] pop_log[$], push_log[$];
  logic [7:0] data_log[$];
  int         pop_cyc[$], push_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic set_din(input int k, input logic [7:0] w);
    case (k)
      0: bus.data_in0 = w;
      1: bus.data_in1 = w;
      2: bus.data_in2 = w;
      default: bus.data_in3 = w;
    endcase
  endtask

  task automatic load(input int k, input logic [7:0] w);
    srcq[k].push_back(w);
    bus.fifo_empty[k] = 1'b0;
  endtask

  task automatic fifo_apply();
    for (int k = 0; k < 4; k++) begin
      if (pend1[k] && srcq[k].size() > 0) set_din(k, srcq[k].pop_front());
      bus.fifo_empty[k] = (srcq[k].size() == 0);
    end
    pend1 = pend0;
  endtask

  task automatic predict();
    logic [3:0] np, nps;
    logic [7:0] nd;
    logic       ni, ne;
    logic [4:0] nc;
    int         g;
    if (!reset) begin
      m_init = 1'b1; m_ptr = 0; m_last = -1; evq.delete();
      exp_pop = '0; exp_push = '0; exp_data = '0;
      exp_idle = 1'b0; exp_err = 1'b0; exp_cnt = '0;
      return;
    end
    nc  = exp_cnt + ((exp_push != 4'd0) ? 5'd1 : 5'd0);
    ne  = exp_err | (|bus.fifo_error);
    nps = '0;
    nd  = exp_data;
    if (evq.size() > 0 && evq[0].due == cyc + 1) begin
      nps = evq[0].dst;
      nd  = evq[0].word;
      void'(evq.pop_front());
    end
    np = '0;
    g  = -1;
    if (m_init) begin
      ni = 1'b1;
      m_init = 1'b0;
    end else if (|bus.dest_pause) begin
      ni = 1'b0;
    end else begin
      for (int i = 0; i < 4 && g < 0; i++) begin
        int q;
        q = (m_ptr + i) % 4;
        if (!bus.fifo_empty[q] && q != m_last) g = q;
      end
      ni = (g < 0);
    end
    if (g >= 0) begin
      logic [7:0] w;
      w = (srcq[g].size() > 0) ? srcq[g][0] : 8'h00;
      np[g] = 1'b1;
      m_ptr = (g + 1) % 4;
      evq.push_back('{due: cyc + 3, dst: 4'b0001 << w[7:6], word: w});
    end
    m_last   = g;
    exp_pop  = np;
    exp_push = nps;
    exp_data = nd;
    exp_idle = ni;
    exp_err  = ne;
    exp_cnt  = nc;
  endtask

  task automatic step();
    fifo_apply();
    predict();
    @(negedge clk);
    cyc++;
    chk("pop", 32'(bus.pop), 32'(exp_pop));
    chk("push", 32'(bus.push), 32'(exp_push));
    chk("data_out", 32'(bus.data_out), 32'(exp_data));
    chk("idle", 32'(bus.idle), 32'(exp_idle));
    chk("err", 32'(bus.err), 32'(exp_err));
    chk("word_count", 32'(bus.word_count), 32'(exp_cnt));
    if (bus.pop != 4'd0) begin pop_log.push_back(bus.pop); pop_cyc.push_back(cyc); end
    if (bus.push != 4'd0) begin
      push_log.push_back(bus.push); data_log.push_back(bus.data_out); push_cyc.push_back(cyc);
    end
    pend0 = bus.pop;
  endtask

  task automatic clear_logs();
    pop_log.delete(); push_log.delete(); data_log.delete();
    pop_cyc.delete(); push_cyc.delete();
  endtask

  logic [3:0] rr_pop  [4];
  logic [7:0] rr_data [4];

  initial begin
    bus.fifo_empty = 4'hF; bus.fifo_error = '0; bus.dest_pause = '0;
    bus.data_in0 = '0; bus.data_in1 = '0; bus.data_in2 = '0; bus.data_in3 = '0;
    pend0 = '0; pend1 = '0;
    m_init = 1'b1; m_ptr = 0; m_last = -1;
    exp_pop = '0; exp_push = '0; exp_data = '0; exp_idle = 1'b0; exp_err = 1'b0; exp_cnt = '0;
    rr_pop  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rr_data = '{8'h03, 8'h44, 8'h85, 8'hC6};

    // Reset held, then released with all sources empty
    repeat (2) step();
    reset = 1'b1;
    #1 chk("init_idle", 32'(bus.idle), 32'd0);
    step();
    chk("post_init_idle", 32'(bus.idle), 32'd1);
    chk("post_init_pop", 32'(bus.pop), 32'd0);
    chk("post_init_count", 32'(bus.word_count), 32'd0);
    repeat (2) step();

    // Round robin over four single-word queues
    clear_logs();
    load(0, 8'h03); load(1, 8'h44); load(2, 8'h85); load(3, 8'hC6);
    repeat (10) step();
    chk("rr_pop_n", 32'(pop_log.size()), 32'd4);
    chk("rr_push_n", 32'(push_log.size()), 32'd4);
    if (pop_log.size() == 4 && push_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_pop_seq", 32'(pop_log[i]), 32'(rr_pop[i]));
        chk("rr_pop_cyc", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
        chk("rr_push_seq", 32'(push_log[i]), 32'(rr_pop[i]));
        chk("rr_data_seq", 32'(data_log[i]), 32'(rr_data[i]));
        chk("rr_latency", 32'(push_cyc[i] - pop_cyc[i]), 32'd2);
      end
    end
    chk("rr_count", 32'(bus.word_count), 32'd4);

    // Single busy queue: hold-off gives one pop every other cycle
    clear_logs();
    load(2, 8'h11); load(2, 8'h52); load(2, 8'h93);
    repeat (12) step();
    chk("single_pop_n", 32'(pop_log.size()), 32'd3);
    chk("single_push_n", 32'(push_log.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("single_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
      chk("single_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
    end
    if (push_log.size() == 3) chk("single_dest2", 32'(push_log[2]), 32'b0100);
    chk("single_count", 32'(bus.word_count), 32'd7);

    // Back-pressure mid-stream, then resume
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      load(0, 8'(8'h20 + 8'(i * 64)));
      load(1, 8'(8'h31 + 8'(i * 64)));
    end
    repeat (3) step();
    bus.dest_pause = 4'b0010;
    step();
    chk("pause_no_pop", 32'(bus.pop), 32'd0);
    repeat (3) step();
    chk("pause_pop", 32'(bus.pop), 32'd0);
    chk("pause_push", 32'(bus.push), 32'd0);
    chk("pause_idle", 32'(bus.idle), 32'd0);
    bus.dest_pause = 4'b0000;
    repeat (20) step();
    chk("pause_total", 32'(push_log.size()), 32'd8);
    chk("pause_count", 32'(bus.word_count), 32'd15);

    // Pause while every source is empty: pause wins over idle
    bus.dest_pause = 4'b1111;
    repeat (2) step();
    chk("pause_empty_idle", 32'(bus.idle), 32'd0);
    bus.dest_pause = 4'b0000;
    repeat (2) step();

    // Sticky error
    bus.fifo_error = 4'b1000;
    step();
    bus.fifo_error = 4'b0000;
    repeat (5) step();
    chk("err_sticky", 32'(bus.err), 32'd1);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) begin
      load(0, 8'(8'h05 + 8'(i * 80)));
      load(1, 8'(8'h46 + 8'(i * 80)));
    end
    repeat (4) step();
    #2 reset = 1'b0;
    #1;
    chk("rst_pop", 32'(bus.pop), 32'd0);
    chk("rst_push", 32'(bus.push), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_idle", 32'(bus.idle), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_count", 32'(bus.word_count), 32'd0);
    for (int k = 0; k < 4; k++) srcq[k].delete();
    pend0 = '0; pend1 = '0; bus.fifo_empty = 4'hF;
    repeat (2) step();
    reset = 1'b1;
    clear_logs();
    repeat (6) step();
    chk("rst_no_push", 32'(push_log.size()), 32'd0);

    // 33 words through the counter: wraps to 1
    clear_logs();
    for (int i = 0; i < 33; i++) load(i % 4, 8'(i * 29 + 7));
    repeat (70) step();
    chk("wrap_pushes", 32'(push_log.size()), 32'd33);
    chk("wrap_count", 32'(bus.word_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_4x8.md
# arbiter_rr_4x8

Four-input round-robin arbiter and router that drains four upstream 6x8 virtual-channel FIFOs and forwards each popped word to one of four downstream 6x8 FIFOs. The destination is selected by the two MSBs of the word. The block sits directly downstream of the VC FIFO bank: it drives their `read` strobes and consumes their `data_out_pop`, `fifo_empty` and `fifo_error` outputs. It honours downstream back-pressure through the destinations' `fifo_pause` / `almost_full` flags.

## Interface
- `DATA_SIZE`, 8: word width; must be ≥ 3.
- `NUM_Q`, 4: number of source and destination queues; fixed at 4 (2-bit destination field).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `fifo_empty`  in  4  `fifo_empty` of source FIFO i on bit i.
- `fifo_error`  in  4  `fifo_error` of source FIFO i on bit i.
- `data_in0` … `data_in3`  in  DATA_SIZE each  `data_out_pop` of source FIFOs 0-3.
- `dest_pause`  in  4  `fifo_pause` OR `almost_full` of destination FIFO j on bit j.
- `pop`  out  4  registered, one-hot-or-zero read strobe to source FIFOs.
- `push`  out  4  registered, one-hot-or-zero write strobe to destination FIFOs.
- `data_out`  out  DATA_SIZE  registered word to destinations, shared bus.
- `idle`  out  1  high in state IDLE.
- `err`  out  1  sticky; set when any `fifo_error` bit is seen high.
- `word_count`  out  5  count of words pushed; wraps 31→0.

## Operation
- Reset values (while `reset` = 0): `pop` = 0, `push` = 0, `data_out` = 0, `idle` = 0, `err` = 0, `word_count` = 0, RR pointer = 0, state = INIT.
- States:
  - INIT: one cycle after reset release, then IDLE.
  - IDLE: no eligible queue.
  - ACTIVE: a grant is issued this cycle.
  - PAUSE: any `dest_pause` bit is high.
- Transitions, evaluated every cycle, PAUSE priority highest:
  - any `dest_pause` → PAUSE;
  - else an eligible queue exists → ACTIVE;
  - else → IDLE.
- Eligibility of queue i: `fifo_empty[i]` = 0, and queue i was not granted in the previous cycle (one-cycle hold-off covers registered empty-flag lag).
- Grant:
  - The search starts at pointer p and proceeds p, p+1, …, wrapping mod 4.
  - The first eligible queue k gets `pop[k]` = 1 next cycle.
  - The pointer becomes k+1 mod 4.
  - No grants are issued in PAUSE or IDLE, and the pointer holds.
- Routing:
  - One cycle after `pop[k]` is high, `data_ink` is valid. The block registers it into `data_out`.
  - It asserts `push[j]`, with j = `data_ink[DATA_SIZE-1:DATA_SIZE-2]`.
- In-flight words (popped before a pause) are always delivered; pause never drops or stalls a word in the pipeline.
- `word_count` increments by 1 on every cycle with a `push` bit set; modulo 32.
- `err` is sticky until reset. Errors do not stop arbitration.
- Reset mid-operation: in-flight words are discarded, all outputs clear asynchronously, and restart goes through INIT.

## Timing
- Cycle N: state ACTIVE, grant decided.
- Edge ending N: `pop[k]` = 1 during N+1.
- N+1: the source FIFO samples `read` at the edge ending N+1, and `data_ink` is valid during N+2.
- Edge ending N+2: `push[j]` and `data_out` are valid during N+3.
- Pop-to-push latency: 2 cycles.
- Throughput: 1 word/cycle when ≥ 2 queues are non-empty. A single busy queue yields 1 word per 2 cycles.
- Pause response: `dest_pause` high in cycle N means no `pop` in N+1. At most 2 words are already in flight, so the downstream almost_full threshold must leave ≥ 2 free entries.
- Simultaneous pause and empty: PAUSE wins, and `idle` = 0.
- `pop` and `push` are never high for two different bits in the same cycle.

## Test plan
- Reset then all empty:
  - `reset` low→high, `fifo_empty` = 4'b1111 → INIT for 1 cycle, then `idle` = 1, `pop` = 0, `word_count` = 0.
- Round robin:
  - Queues 0-3 each hold 1 word, 8'h03, 8'h44, 8'h85, 8'hC6 → `pop` sequence 0001, 0010, 0100, 1000 on consecutive cycles.
  - `push` sequence 0001, 0010, 0100, 1000 two cycles later, with `data_out` 03, 44, 85, C6.
  - `word_count` = 4.
- Single queue with hold-off:
  - Only queue 2 non-empty with 3 words → `pop` = 0100 on alternating cycles only; 3 pushes total.
- Back-pressure:
  - `dest_pause[1]` raised mid-stream → `pop` = 0 from the next cycle, the ≤ 2 in-flight words still pushed, state PAUSE.
  - On release, arbitration resumes from the saved pointer.
- Error and wrap:
  - Pulse `fifo_error[3]` for 1 cycle → `err` = 1 and stays 1.
  - Push 33 words → `word_count` = 1.
- Async reset mid-transfer:
  - `reset` = 0 while `pop`/`push` are active → all outputs 0 within the same cycle, with no further push after release until a new grant.
